// File: rtl/score_keeper_pkg.sv
// Shared state encodings, BCD limits and the 2-digit saturating BCD increment
// used by both the score counter and the high-score compare path.
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_OVER_HOLD = 2'd1,
    ST_OVER_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0] SCORE_MAX     = 8'h99;

  // {tens, ones} + 1 in BCD, holding at 99.
  function automatic logic [7:0] bcd_inc2(input logic [7:0] value);
    logic [7:0] result;
    if (value == SCORE_MAX) begin
      result = value;
    end else if (value[3:0] == BCD_MAX_DIGIT) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_counter2.sv
// Two-digit saturating BCD counter with synchronous clear and increment enable.
module bcd_counter2
  import score_keeper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      {tens, ones} <= bcd_inc2({tens, ones});
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score, high score and game-over sequencing for the text overlay; every
// output is a register so the pixel-rate renderer can sample it at any time.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int HOLD_FRAMES = 60,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       eat,
  input  logic       collide,
  input  logic       restart,
  output logic [3:0] score1,
  output logic [3:0] score0,
  output logic [3:0] high1,
  output logic [3:0] high0,
  output logic       g_over,
  output logic       new_high
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       high;
  logic [7:0]       score_now;
  logic [7:0]       score_final;
  logic             score_inc;
  logic             score_clear;

  assign score_now   = {score1, score0};
  // A point scored on the collision cycle still counts toward the high score.
  assign score_final = eat ? bcd_inc2(score_now) : score_now;
  assign score_inc   = (state == ST_PLAY) && eat;
  assign score_clear = (state == ST_OVER_WAIT) && restart;

  assign high1 = high[7:4];
  assign high0 = high[3:0];

  bcd_counter2 u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .tens  (score1),
    .ones  (score0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PLAY;
      hold_cnt <= '0;
      high     <= 8'h00;
      g_over   <= 1'b0;
      new_high <= 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (collide) begin
            state    <= ST_OVER_HOLD;
            g_over   <= 1'b1;
            hold_cnt <= '0;
            // Packed BCD orders the same as plain unsigned binary.
            if (score_final > high) begin
              high     <= score_final;
              new_high <= 1'b1;
            end else begin
              new_high <= 1'b0;
            end
          end
        end
        ST_OVER_HOLD: begin
          if (frame_tick) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            if (hold_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
              state <= ST_OVER_WAIT;
            end
          end
        end
        ST_OVER_WAIT: begin
          if (restart) begin
            state    <= ST_PLAY;
            g_over   <= 1'b0;
            new_high <= 1'b0;
          end
        end
        default: begin
          state  <= ST_PLAY;
          g_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with a short 4-frame hold.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       eat = 1'b0;
  logic       collide = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] score1, score0, high1, high0;
  logic       g_over, new_high;

  int tests = 0;
  int failures = 0;

  score_keeper #(.HOLD_FRAMES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .eat        (eat),
    .collide    (collide),
    .restart    (restart),
    .score1     (score1),
    .score0     (score0),
    .high1      (high1),
    .high0      (high0),
    .g_over     (g_over),
    .new_high   (new_high)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_eats(input int n);
    for (int i = 0; i < n; i++) begin
      eat = 1'b1;
      tick();
      eat = 1'b0;
    end
  endtask

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    eat = 1'b1;
    tick();
    eat = 1'b0;
    do_reset();
    tests++;
    if ({score1, score0, high1, high0} !== 16'h0000 || g_over !== 1'b0 || new_high !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: score=%h%h high=%h%h g_over=%b new_high=%b, expected 00 00 0 0",
               score1, score0, high1, high0, g_over, new_high);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp1, exp0;
    for (int i = 0; i < 12; i++) begin
      exp1 = 4'(i / 10);
      exp0 = 4'(i % 10);
      eat = 1'b1;
      #1;
      tests++;
      if (score1 !== exp1 || score0 !== exp0) begin
        failures++;
        $display("[TB] FAIL count_early[%0d]: score=%h%h expected %h%h", i, score1, score0, exp1, exp0);
      end
      tick();
      eat = 1'b0;
      exp1 = 4'((i + 1) / 10);
      exp0 = 4'((i + 1) % 10);
      tests++;
      if (score1 !== exp1 || score0 !== exp0) begin
        failures++;
        $display("[TB] FAIL count_step[%0d]: score=%h%h expected %h%h", i, score1, score0, exp1, exp0);
      end
    end
    tests++;
    if ({score1, score0} !== 8'h12 || {high1, high0} !== 8'h00 || g_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL count_final: score=%h%h high=%h%h g_over=%b, expected 12 00 0",
               score1, score0, high1, high0, g_over);
    end
  endtask

  task automatic test_carry_saturate();
    do_reset();
    do_eats(9);
    tests++;
    if ({score1, score0} !== 8'h09) begin
      failures++;
      $display("[TB] FAIL score_09: score=%h%h expected 09", score1, score0);
    end
    do_eats(1);
    tests++;
    if ({score1, score0} !== 8'h10) begin
      failures++;
      $display("[TB] FAIL carry_10: score=%h%h expected 10", score1, score0);
    end
    do_eats(88);
    tests++;
    if ({score1, score0} !== 8'h98) begin
      failures++;
      $display("[TB] FAIL score_98: score=%h%h expected 98", score1, score0);
    end
    for (int i = 0; i < 3; i++) begin
      do_eats(1);
      tests++;
      if ({score1, score0} !== 8'h99) begin
        failures++;
        $display("[TB] FAIL saturate[%0d]: score=%h%h expected 99", i, score1, score0);
      end
    end
  endtask

  task automatic test_collide();
    do_reset();
    do_eats(15);
    collide = 1'b1;
    #1;
    tests++;
    if (g_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL collide_early: g_over=%b expected 0", g_over);
    end
    tick();
    collide = 1'b0;
    tests++;
    if (g_over !== 1'b1 || {high1, high0} !== 8'h15 || new_high !== 1'b1 || {score1, score0} !== 8'h15) begin
      failures++;
      $display("[TB] FAIL collide_over: g_over=%b high=%h%h new_high=%b score=%h%h, expected 1 15 1 15",
               g_over, high1, high0, new_high, score1, score0);
    end
    do_eats(3);
    tests++;
    if ({score1, score0} !== 8'h15 || g_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL frozen_score: score=%h%h g_over=%b expected 15 1", score1, score0, g_over);
    end
  endtask

  task automatic test_restart_hold();
    restart = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      do_frames(1);
      tests++;
      if (g_over !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hold_frame[%0d]: g_over=%b expected 1", k, g_over);
      end
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tests++;
    if (g_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL enter_wait: g_over=%b expected 1", g_over);
    end
    tick();
    restart = 1'b0;
    tests++;
    if (g_over !== 1'b0 || {score1, score0} !== 8'h00 || {high1, high0} !== 8'h15 || new_high !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart_play: g_over=%b score=%h%h high=%h%h new_high=%b, expected 0 00 15 0",
               g_over, score1, score0, high1, high0, new_high);
    end
  endtask

  task automatic test_second_game();
    do_eats(7);
    collide = 1'b1;
    tick();
    collide = 1'b0;
    tests++;
    if (g_over !== 1'b1 || {high1, high0} !== 8'h15 || new_high !== 1'b0 || {score1, score0} !== 8'h07) begin
      failures++;
      $display("[TB] FAIL low_game: g_over=%b high=%h%h new_high=%b score=%h%h, expected 1 15 0 07",
               g_over, high1, high0, new_high, score1, score0);
    end
    do_frames(4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests++;
    if (g_over !== 1'b0 || {score1, score0} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL second_restart: g_over=%b score=%h%h expected 0 00", g_over, score1, score0);
    end
    do_eats(15);
    eat = 1'b1;
    collide = 1'b1;
    tick();
    eat = 1'b0;
    collide = 1'b0;
    tests++;
    if ({score1, score0} !== 8'h16 || {high1, high0} !== 8'h16 || new_high !== 1'b1 || g_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL eat_and_collide: score=%h%h high=%h%h new_high=%b g_over=%b, expected 16 16 1 1",
               score1, score0, high1, high0, new_high, g_over);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_frames(1);
    do_reset();
    tests++;
    if (g_over !== 1'b0 || {score1, score0} !== 8'h00 || {high1, high0} !== 8'h00 || new_high !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_hold: g_over=%b score=%h%h high=%h%h new_high=%b, expected 0 00 00 0",
               g_over, score1, score0, high1, high0, new_high);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tests++;
    if (g_over !== 1'b0 || {score1, score0} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL restart_in_play: g_over=%b score=%h%h expected 0 00", g_over, score1, score0);
    end
    do_eats(1);
    tests++;
    if ({score1, score0} !== 8'h01) begin
      failures++;
      $display("[TB] FAIL play_after_reset: score=%h%h expected 01", score1, score0);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_count();
    test_carry_saturate();
    test_collide();
    test_restart_hold();
    test_second_game();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
